ct_had_dbg_reqctrl: RTL and testbench

CT_HAD_DBG_REQCTRL -- requirements
Module: ct_had_dbg_reqctrl

---
 rtl/ct_had_dbg_reqctrl.sv | 104 ++++++++++
 tb/tb_ct_had_dbg_reqctrl.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/ct_had_dbg_reqctrl.sv
// Debug halt/resume request controller: turns synchronized halt/resume events into
// level requests to the core, waits for the core_halted acknowledge, and flags timeouts.
module ct_had_dbg_reqctrl #(
    parameter int unsigned TIMEOUT = 200,
    parameter int unsigned CNT_W   = 8
) (
    input  logic       cpuclk,
    input  logic       cpurst,
    input  logic       halt_pulse,
    input  logic       resume_pulse,
    input  logic       core_halted,
    input  logic       err_clr,
    output logic       halt_req,
    output logic       resume_req,
    output logic [1:0] dbg_state,
    output logic       halt_done,
    output logic       resume_done,
    output logic       timeout_err
);

    typedef enum logic [1:0] {
        RUN        = 2'b00,
        HALT_REQ   = 2'b01,
        HALTED     = 2'b10,
        RESUME_REQ = 2'b11
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;

    assign dbg_state = 2'(state);

    // Request outputs are registered alongside the state so they equal a decode of it.
    always_ff @(posedge cpuclk) begin
        if (cpurst) begin
            state       <= RUN;
            cnt         <= '0;
            halt_req    <= 1'b0;
            resume_req  <= 1'b0;
            halt_done   <= 1'b0;
            resume_done <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            halt_done   <= 1'b0;
            resume_done <= 1'b0;
            cnt         <= '0;
            if (err_clr) begin
                timeout_err <= 1'b0;
            end
            case (state)
                RUN: begin
                    if (core_halted) begin
                        state     <= HALTED;
                        halt_done <= 1'b1;
                    end else if (halt_pulse) begin
                        state    <= HALT_REQ;
                        halt_req <= 1'b1;
                    end
                end
                HALT_REQ: begin
                    if (core_halted) begin
                        state     <= HALTED;
                        halt_req  <= 1'b0;
                        halt_done <= 1'b1;
                    end else if (resume_pulse) begin
                        state    <= RUN;
                        halt_req <= 1'b0;
                    end else if (cnt == CNT_LAST) begin
                        // Timeout wins over a same-cycle err_clr.
                        state       <= RUN;
                        halt_req    <= 1'b0;
                        timeout_err <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                HALTED: begin
                    if (!core_halted) begin
                        state <= RUN;
                    end else if (resume_pulse) begin
                        state      <= RESUME_REQ;
                        resume_req <= 1'b1;
                    end
                end
                RESUME_REQ: begin
                    if (!core_halted) begin
                        state       <= RUN;
                        resume_req  <= 1'b0;
                        resume_done <= 1'b1;
                    end else if (cnt == CNT_LAST) begin
                        state       <= HALTED;
                        resume_req  <= 1'b0;
                        timeout_err <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ct_had_dbg_reqctrl.sv
// Directed scoreboard bench for ct_had_dbg_reqctrl with TIMEOUT=4.
module tb_ct_had_dbg_reqctrl;

    logic       cpuclk = 1'b0;
    logic       cpurst = 1'b0;
    logic       halt_pulse = 1'b0;
    logic       resume_pulse = 1'b0;
    logic       core_halted = 1'b0;
    logic       err_clr = 1'b0;
    logic       halt_req;
    logic       resume_req;
    logic [1:0] dbg_state;
    logic       halt_done;
    logic       resume_done;
    logic       timeout_err;

    ct_had_dbg_reqctrl #(.TIMEOUT(4), .CNT_W(8)) dut (
        .cpuclk      (cpuclk),
        .cpurst      (cpurst),
        .halt_pulse  (halt_pulse),
        .resume_pulse(resume_pulse),
        .core_halted (core_halted),
        .err_clr     (err_clr),
        .halt_req    (halt_req),
        .resume_req  (resume_req),
        .dbg_state   (dbg_state),
        .halt_done   (halt_done),
        .resume_done (resume_done),
        .timeout_err (timeout_err)
    );

    always #5 cpuclk = ~cpuclk;

    // Packed view: {halt_req, resume_req, dbg_state[1:0], halt_done, resume_done, timeout_err}
    localparam logic [6:0] E_RUN      = 7'b0000000;
    localparam logic [6:0] E_RUN_RD   = 7'b0000010;
    localparam logic [6:0] E_RUN_ERR  = 7'b0000001;
    localparam logic [6:0] E_HREQ     = 7'b1001000;
    localparam logic [6:0] E_HREQ_ERR = 7'b1001001;
    localparam logic [6:0] E_HALTED   = 7'b0010000;
    localparam logic [6:0] E_HALT_HD  = 7'b0010100;
    localparam logic [6:0] E_HALT_ERR = 7'b0010001;
    localparam logic [6:0] E_RREQ     = 7'b0111000;

    typedef struct {
        logic [6:0] exp;
        string      tag;
    } sb_entry_t;

    sb_entry_t sb_q[$];
    int vectors = 0;
    int miscompares = 0;

    // Apply one cycle of inputs, expect the given outputs after the next rising edge.
    task automatic step(input logic hp, input logic rp, input logic ch, input logic ec,
                        input logic rst, input logic [6:0] exp, input string tag);
        sb_entry_t e;
        logic [6:0] obs;
        halt_pulse   = hp;
        resume_pulse = rp;
        core_halted  = ch;
        err_clr      = ec;
        cpurst       = rst;
        sb_q.push_back('{exp, tag});
        @(posedge cpuclk);
        #1;
        e = sb_q.pop_front();
        obs = {halt_req, resume_req, dbg_state, halt_done, resume_done, timeout_err};
        vectors++;
        assert (obs === e.exp) else begin
            miscompares++;
            $error("FAIL %s observed=%b expected=%b", e.tag, obs, e.exp);
        end
    endtask

    initial begin
        //   hp  rp  ch  ec  rst
        step(0, 0, 0, 0, 1, E_RUN,      "reset");
        step(0, 1, 0, 0, 0, E_RUN,      "run_resume_ignored");
        // Halt acknowledged after three request cycles
        step(1, 0, 0, 0, 0, E_HREQ,     "halt_req_c0");
        step(0, 0, 0, 0, 0, E_HREQ,     "halt_req_c1");
        step(0, 0, 0, 0, 0, E_HREQ,     "halt_req_c2");
        step(0, 0, 1, 0, 0, E_HALT_HD,  "halt_ack_done");
        step(0, 0, 1, 0, 0, E_HALTED,   "halt_done_one_cycle");
        step(1, 0, 1, 0, 0, E_HALTED,   "halted_halt_ignored");
        // Resume acknowledged
        step(0, 1, 1, 0, 0, E_RREQ,     "resume_req_c0");
        step(0, 0, 1, 0, 0, E_RREQ,     "resume_req_c1");
        step(0, 0, 0, 0, 0, E_RUN_RD,   "resume_ack_done");
        step(0, 0, 0, 0, 0, E_RUN,      "resume_done_one_cycle");
        // Halt timeout: request high exactly four cycles
        step(1, 0, 0, 0, 0, E_HREQ,     "to_halt_c0");
        step(0, 0, 0, 0, 0, E_HREQ,     "to_halt_c1");
        step(0, 0, 0, 0, 0, E_HREQ,     "to_halt_c2");
        step(0, 0, 0, 0, 0, E_HREQ,     "to_halt_c3");
        step(0, 0, 0, 0, 0, E_RUN_ERR,  "halt_timeout_err");
        step(0, 0, 0, 0, 0, E_RUN_ERR,  "err_sticky");
        step(0, 0, 0, 1, 0, E_RUN,      "err_clr");
        // Abort by resume at cnt=1
        step(1, 0, 0, 0, 0, E_HREQ,     "abort_c0");
        step(0, 0, 0, 0, 0, E_HREQ,     "abort_c1");
        step(0, 1, 0, 0, 0, E_RUN,      "abort_no_err");
        // Timeout with simultaneous err_clr
        step(1, 0, 0, 0, 0, E_HREQ,     "to2_c0");
        step(0, 0, 0, 0, 0, E_HREQ,     "to2_c1");
        step(0, 0, 0, 1, 0, E_HREQ,     "to2_c2_clr_noop");
        step(0, 0, 0, 0, 0, E_HREQ,     "to2_c3");
        step(0, 0, 0, 1, 0, E_RUN_ERR,  "timeout_beats_clr");
        step(1, 0, 0, 0, 0, E_HREQ_ERR, "req_with_err_set");
        step(0, 0, 0, 1, 0, E_HREQ,     "clr_during_req");
        step(0, 0, 1, 0, 0, E_HALT_HD,  "halt_ack_after_clr");
        step(0, 0, 0, 0, 0, E_RUN,      "halted_core_exit_no_done");
        // Simultaneous halt+resume pulses in RUN
        step(1, 1, 0, 0, 0, E_HREQ,     "both_pulses_run");
        step(0, 1, 1, 0, 0, E_HALT_HD,  "ack_beats_resume");
        step(0, 0, 0, 0, 0, E_RUN,      "back_to_run");
        // Core halts spontaneously
        step(0, 0, 1, 0, 0, E_HALT_HD,  "spont_halt_done");
        step(0, 0, 1, 0, 0, E_HALTED,   "spont_halted");
        // Resume timeout returns to HALTED without halt_done
        step(0, 1, 1, 0, 0, E_RREQ,     "to_res_c0");
        step(1, 1, 1, 0, 0, E_RREQ,     "to_res_c1_pulses_ignored");
        step(0, 0, 1, 0, 0, E_RREQ,     "to_res_c2");
        step(0, 0, 1, 0, 0, E_RREQ,     "to_res_c3");
        step(0, 0, 1, 0, 0, E_HALT_ERR, "resume_timeout_err");
        step(0, 0, 1, 1, 0, E_HALTED,   "err_clr_halted");
        // Reset mid-resume and mid-halt request
        step(0, 1, 1, 0, 0, E_RREQ,     "pre_rst_rreq");
        step(1, 1, 1, 1, 1, E_RUN,      "rst_during_rreq");
        step(0, 0, 0, 0, 0, E_RUN,      "post_rst_idle");
        step(1, 0, 0, 0, 0, E_HREQ,     "pre_rst_hreq");
        step(0, 0, 1, 0, 1, E_RUN,      "rst_beats_ack");
        step(0, 0, 0, 0, 0, E_RUN,      "post_rst_idle2");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
